// File: rtl/musa_fetch_pkg.sv
// Shared definitions for the MUSA fetch unit: next-PC select codes and the
// fetch FSM state encoding.
package musa_fetch_pkg;

  localparam logic [2:0] BR_SEQ     = 3'b000;
  localparam logic [2:0] BR_JREG    = 3'b001;
  localparam logic [2:0] BR_JIMM    = 3'b010;
  localparam logic [2:0] BR_HALT    = 3'b011;
  localparam logic [2:0] BR_JPC     = 3'b100;
  localparam logic [2:0] BR_CALL    = 3'b101;
  localparam logic [2:0] BR_RET     = 3'b110;
  localparam logic [2:0] BR_SEQ_ALT = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/musa_ret_stack.sv
// Return-address stack with a wrapping write pointer and a saturating
// occupancy count; callers decide whether to honour full/empty.
module musa_ret_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;

  // ptr points at the next free slot, so the top entry sits one below it
  assign top   = mem[ptr - PTR_ONE];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= data_in;
      ptr      <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop) begin
      ptr <= ptr - PTR_ONE;
      if (!empty) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/musa_fetch_unit.sv
// MUSA fetch unit: PC, return stack, next-PC selection and handshaked fetch.
// Define MUSA_FETCH_RAS_CHECK_EN for stack full/empty checking and sticky flags.
module musa_fetch_unit
  import musa_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 18,
  parameter int                INSTR_W   = 32,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               step,
  input  logic [2:0]         br_sel,
  input  logic               brfl_en,
  input  logic               brfl_flag,
  input  logic [ADDR_W-1:0]  jreg_addr,
  input  logic [ADDR_W-1:0]  imm_addr,
  input  logic               resume,
  output logic               halted,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state;
  logic              retire, push_req, pop_req, go_halt;
  logic              ras_full, ras_empty;
  logic [ADDR_W-1:0] next_pc, seq_pc, ras_top;

  assign seq_pc    = pc + PC_ONE;
  assign imem_addr = pc;
  assign retire    = (state == ST_HOLD) && step;

`ifdef MUSA_FETCH_RAS_CHECK_EN
  logic set_ovf, set_unf;
`else
  logic ras_unused;
  assign ras_unused = ras_full ^ ras_empty;
`endif

  // A taken BRFL overrides br_sel entirely; a not-taken BRFL falls through to pc+1.
  always_comb begin
    next_pc  = seq_pc;
    push_req = 1'b0;
    pop_req  = 1'b0;
    go_halt  = 1'b0;
`ifdef MUSA_FETCH_RAS_CHECK_EN
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
`endif
    if (brfl_en) begin
      if (brfl_flag) next_pc = imm_addr;
    end else begin
      case (br_sel)
        BR_SEQ, BR_SEQ_ALT: next_pc = seq_pc;
        BR_JREG: next_pc = jreg_addr;
        BR_JIMM: next_pc = imm_addr;
        BR_HALT: begin
          next_pc = pc;
          go_halt = 1'b1;
        end
        BR_JPC: next_pc = pc + imm_addr;
        BR_CALL: begin
          next_pc = imm_addr;
`ifdef MUSA_FETCH_RAS_CHECK_EN
          push_req = !ras_full;
          set_ovf  = ras_full;
`else
          push_req = 1'b1;
`endif
        end
        BR_RET: begin
`ifdef MUSA_FETCH_RAS_CHECK_EN
          if (ras_empty) begin
            set_unf = 1'b1;
          end else begin
            next_pc = ras_top;
            pop_req = 1'b1;
          end
`else
          next_pc = ras_top;
          pop_req = 1'b1;
`endif
        end
        default: next_pc = seq_pc;
      endcase
    end
  end

  musa_ret_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (retire && push_req),
    .pop     (retire && pop_req),
    .data_in (seq_pc),
    .top     (ras_top),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  // imem_valid only counts once our request is visible, so stale responses are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_valid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (step) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            if (go_halt) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          if (resume) begin
            pc       <= seq_pc;
            halted   <= 1'b0;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef MUSA_FETCH_RAS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (retire) begin
      if (set_ovf) ras_overflow  <= 1'b1;
      if (set_unf) ras_underflow <= 1'b1;
    end
  end
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule
